// File: rtl/core_dispatch.sv
// core_dispatch
//   Launcher for the control units of the multicore matrix multiplier.
//   A start pulses core_rst for two cycles and then drives RUN onto every
//   selected core's status word. The block then waits until all selected
//   cores report end_process and raises done. If they have not finished
//   within TIMEOUT_CYC wait cycles it raises ABORT and sets timeout instead.
//
// Ports
//   clock_i        system clock, all logic on posedge
//   reset_i        synchronous, active-high
//   start_i        launch request, only looked at in IDLE
//   core_mask_i    cores to launch, captured when a start is accepted
//   end_process_i  per-core finish level from each control unit
//   status_o       core i on bits [2i+1:2i]: 00 idle, 01 run, 10 abort
//   core_rst_o     reset to the cores, high while clearing
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse on successful completion
//   timeout_o      sticky abort flag, cleared by the next accepted start
//   run_cycles_o   wait cycles of the last/current run, frozen at the end
//
// state  | meaning
// IDLE   | waiting for a start with a non-zero mask
// CLR    | two cycles of core_rst, finish flags cleared
// LAUNCH | one cycle, RUN driven onto the selected cores
// WAIT   | counting cycles, collecting finishes
// DONE   | one cycle, done pulse
// ABORT  | one cycle, ABORT on the selected cores, timeout set

module core_dispatch #(
  parameter int NUM_CORES   = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NUM_CORES-1:0]   core_mask_i,
  input  logic [NUM_CORES-1:0]   end_process_i,
  output logic [2*NUM_CORES-1:0] status_o,
  output logic                   core_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [CNT_W-1:0]       run_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_DONE, S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_t                 state_q;
  logic [NUM_CORES-1:0]   mask_q;
  logic [NUM_CORES-1:0]   fin_q;
  logic [NUM_CORES-1:0]   fin_d;
  logic                   clr_cnt_q;
  logic [2*NUM_CORES-1:0] status_q;
  logic                   core_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   timeout_q;
  logic [CNT_W-1:0]       run_cycles_q;
  logic [CNT_W-1:0]       run_cycles_d;
  logic [2*NUM_CORES-1:0] run_status;
  logic [2*NUM_CORES-1:0] abort_status;
  logic                   all_fin;
  logic                   at_limit;

  always_comb begin
    run_status   = '0;
    abort_status = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      run_status[2*i +: 2]   = mask_q[i] ? 2'b01 : 2'b00;
      abort_status[2*i +: 2] = mask_q[i] ? 2'b10 : 2'b00;
    end
  end

  // run_cycles_q is still zero only on the first WAIT cycle; end_process
  // there may be a level left over from the previous run, so it is skipped.
  assign fin_d        = (run_cycles_q == '0) ? fin_q : (fin_q | (end_process_i & mask_q));
  assign all_fin      = (fin_d == mask_q);
  assign at_limit     = (run_cycles_q == LIMIT);
  assign run_cycles_d = (&run_cycles_q) ? run_cycles_q : run_cycles_q + CNT_W'(1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      fin_q        <= '0;
      clr_cnt_q    <= 1'b0;
      status_q     <= '0;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && (core_mask_i != '0)) begin
            mask_q       <= core_mask_i;
            fin_q        <= '0;
            clr_cnt_q    <= 1'b0;
            timeout_q    <= 1'b0;
            run_cycles_q <= '0;
            status_q     <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_CLR;
          end
        end
        S_CLR: begin
          if (!clr_cnt_q) begin
            clr_cnt_q <= 1'b1;
          end else begin
            fin_q      <= '0;
            core_rst_q <= 1'b0;
            status_q   <= run_status;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          run_cycles_q <= run_cycles_d;
          fin_q        <= fin_d;
          // Completion wins over a timeout landing on the same cycle.
          if (all_fin) begin
            status_q <= '0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (at_limit) begin
            status_q  <= abort_status;
            timeout_q <= 1'b1;
            state_q   <= S_ABORT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ABORT: begin
          status_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign status_o     = status_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign run_cycles_o = run_cycles_q;

endmodule

// File: tb/tb_core_dispatch.sv
// Two dispatchers share one stimulus stream: one with the default timeout and
// one with TIMEOUT_CYC=16. For every run the expected outcome is worked out up
// front from the finish times (completion index, done or abort, end index),
// and each cycle's outputs follow from where that cycle sits in the run.
module tb_core_dispatch;

  localparam int T_A = 50000;
  localparam int T_B = 16;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [3:0]  core_mask_i;
  logic [3:0]  end_process_i;

  logic [7:0]  st_a, st_b;
  logic        crst_a, crst_b, busy_a, busy_b, done_a, done_b, to_a, to_b;
  logic [15:0] rc_a, rc_b;

  int vectors     = 0;
  int miscompares = 0;
  bit          prev_to[2];
  logic [15:0] prev_rc[2];

  always #5 clock_i = ~clock_i;

  core_dispatch #(.NUM_CORES(4), .CNT_W(16), .TIMEOUT_CYC(T_A)) u_dut_a (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .core_mask_i(core_mask_i), .end_process_i(end_process_i),
    .status_o(st_a), .core_rst_o(crst_a), .busy_o(busy_a), .done_o(done_a),
    .timeout_o(to_a), .run_cycles_o(rc_a)
  );

  core_dispatch #(.NUM_CORES(4), .CNT_W(16), .TIMEOUT_CYC(T_B)) u_dut_b (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .core_mask_i(core_mask_i), .end_process_i(end_process_i),
    .status_o(st_b), .core_rst_o(crst_b), .busy_o(busy_b), .done_o(done_b),
    .timeout_o(to_b), .run_cycles_o(rc_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed expectation: {status[7:0], core_rst, busy, done, timeout, run_cycles[15:0]}
  task automatic check_inst(input int k, input int n, input logic [27:0] ex);
    logic [27:0] obs;
    string nm;
    obs = (k == 0) ? {st_a, crst_a, busy_a, done_a, to_a, rc_a}
                   : {st_b, crst_b, busy_b, done_b, to_b, rc_b};
    nm = $sformatf("%s n=%0d", (k == 0) ? "dflt" : "to16", n);
    check_val({nm, " status"},     32'(obs[27:20]), 32'(ex[27:20]));
    check_val({nm, " core_rst"},   32'(obs[19]),    32'(ex[19]));
    check_val({nm, " busy"},       32'(obs[18]),    32'(ex[18]));
    check_val({nm, " done"},       32'(obs[17]),    32'(ex[17]));
    check_val({nm, " timeout"},    32'(obs[16]),    32'(ex[16]));
    check_val({nm, " run_cycles"}, 32'(obs[15:0]),  32'(ex[15:0]));
  endtask

  // n counts posedges from the one that accepts start. The run ends (DONE or
  // ABORT visible) at n = 4+e where e is the WAIT index of the deciding cycle.
  function automatic logic [27:0] expect_out(input int n, input logic [3:0] m,
                                             input int e, input bit ok, input int r);
    logic [7:0]  run_s;
    logic [7:0]  ab_s;
    logic [15:0] rc;
    run_s = '0;
    ab_s  = '0;
    for (int i = 0; i < 4; i++) begin
      run_s[2*i +: 2] = m[i] ? 2'b01 : 2'b00;
      ab_s[2*i +: 2]  = m[i] ? 2'b10 : 2'b00;
    end
    rc = 16'(e + 1);
    if (r >= 0 && n >= r) return '0;
    if (n <= 1)           return {8'h00, 4'b1100, 16'h0000};
    if (n == 2)           return {run_s, 4'b0100, 16'h0000};
    if (n <= 3 + e)       return {run_s, 4'b0100, 16'(n - 3)};
    if (n == 4 + e)       return ok ? {8'h00, 4'b0110, rc} : {ab_s, 4'b0101, rc};
    return {8'h00, 3'b000, !ok, rc};
  endfunction

  // f = WAIT index at which a core raises end_process (held), -1 = never.
  // r = posedge index at which reset is sampled, -1 = none.
  task automatic run_case(input logic [3:0] m, input int f0, input int f1,
                          input int f2, input int f3, input int r, input bit noise);
    int   f[4];
    int   c;
    bit   never;
    int   e[2];
    bit   ok[2];
    int   n_max;
    int   emin;
    int   t;
    logic [3:0] ep;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    c = 0;
    never = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (f[i] < 0) never = 1'b1;
        else if (((f[i] < 1) ? 1 : f[i]) > c) c = (f[i] < 1) ? 1 : f[i];
      end
    end
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? T_A : T_B;
      ok[k] = !never && (c <= t - 1);
      e[k]  = ok[k] ? c : t - 1;
    end
    emin  = (e[0] < e[1]) ? e[0] : e[1];
    n_max = (r >= 0) ? r + 2 : 6 + ((e[0] > e[1]) ? e[0] : e[1]);

    for (int k = 0; k < 2; k++)
      check_inst(k, -1, {8'h00, 3'b000, prev_to[k], prev_rc[k]});

    start_i       = 1'b1;
    core_mask_i   = m;
    end_process_i = noise ? (4'($urandom) & ~m) : 4'b0000;
    for (int n = 0; n <= n_max; n++) begin
      @(posedge clock_i);
      #1;
      start_i     = 1'b0;
      core_mask_i = 4'($urandom);
      if (noise && (n + 1 <= 4 + emin) && (r < 0 || n + 1 < r)) start_i = 1'($urandom);
      reset_i = (r >= 0) && (n + 1 == r);
      ep = noise ? (4'($urandom) & ~m) : 4'b0000;
      for (int i = 0; i < 4; i++)
        if (m[i] && f[i] >= 0 && (n - 3) >= f[i]) ep[i] = 1'b1;
      end_process_i = ep;
      @(negedge clock_i);
      for (int k = 0; k < 2; k++)
        check_inst(k, n, expect_out(n, m, e[k], ok[k], r));
    end
    start_i       = 1'b0;
    reset_i       = 1'b0;
    end_process_i = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      prev_to[k] = (r >= 0) ? 1'b0 : !ok[k];
      prev_rc[k] = (r >= 0) ? 16'h0000 : 16'(e[k] + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i       = 1'b1;
    start_i       = 1'b0;
    core_mask_i   = 4'b0000;
    end_process_i = 4'b0000;
    prev_to[0] = 1'b0; prev_to[1] = 1'b0;
    prev_rc[0] = '0;   prev_rc[1] = '0;
    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(negedge clock_i);
      check_inst(0, -2, 28'h0);
      check_inst(1, -2, 28'h0);
    end

    // start with an empty mask must be ignored
    start_i     = 1'b1;
    core_mask_i = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock_i);
      check_val("mask0 busy a", 32'(busy_a), 32'd0);
      check_val("mask0 busy b", 32'(busy_b), 32'd0);
      check_val("mask0 core_rst a", 32'(crst_a), 32'd0);
    end
    start_i = 1'b0;
    @(negedge clock_i);

    // all four cores, staggered finishes; the 16-cycle unit aborts
    run_case(4'b1111, 5, 9, 12, 20, -1, 1'b0);
    // cores 0 and 2 only, unmasked cores toggle end_process freely
    run_case(4'b0101, 3, -1, 7, -1, -1, 1'b1);
    // core 3 never finishes: short unit aborts, long unit is reset mid-WAIT
    run_case(4'b1111, 2, 4, 6, -1, 30, 1'b1);
    // last finish lands on the timeout cycle of the short unit
    run_case(4'b1100, -1, -1, 4, 15, -1, 1'b0);
    // finish raised on the very first WAIT cycle is only seen a cycle later
    run_case(4'b0010, -1, 0, -1, -1, -1, 1'b0);

    for (int k = 0; k < 20; k++)
      run_case(4'($urandom_range(1, 15)), $urandom_range(0, 30), $urandom_range(0, 30),
               $urandom_range(0, 30), $urandom_range(0, 30), -1, 1'b1);

    // one more check that the last run's result is still held in IDLE
    @(negedge clock_i);
    check_inst(0, -3, {8'h00, 3'b000, prev_to[0], prev_rc[0]});
    check_inst(1, -3, {8'h00, 3'b000, prev_to[1], prev_rc[1]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
